// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: shared state, opcode, alu_op and instruction-class types for the multi-cycle controller
package ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT} state_t;
    localparam logic [3:0] OP_LW   = 4'b0000;
    localparam logic [3:0] OP_SW   = 4'b0001;
    localparam logic [3:0] OP_R    = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_J    = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic addi;
        logic branch_eq;
        logic branch_ne;
        logic jump;
        logic halt;
        logic illegal;
    } cls_t;
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: controller <-> datapath bundle
//   master (controller): in opcode, mem_ack; out ir_load, pc_en, datapath controls, alu_op,
//                        retire_cnt[CNT_W], illegal, fault, halted
//   slave  (datapath/bench): the mirror image
interface mc_control_unit_if #(parameter int CNT_W = 16);
    logic [3:0]       opcode;
    logic             mem_ack;
    logic             ir_load;
    logic             pc_en;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             beq;
    logic             bne;
    logic             jump;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal;
    logic             fault;
    logic             halted;
    modport master (
        input  opcode, mem_ack,
        output ir_load, pc_en, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               beq, bne, jump, alu_op, retire_cnt, illegal, fault, halted
    );
    modport slave (
        output opcode, mem_ack,
        input  ir_load, pc_en, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               beq, bne, jump, alu_op, retire_cnt, illegal, fault, halted
    );
endinterface

// File: rtl/mc_control_unit_decode.sv
// ctrl_decode: registered opcode -> instruction class; macro CTRL_BNE_EN enables 0101 as BNE
//   in  op[4]   registered opcode
//   out cls     one-hot instruction class (illegal when nothing else matches)
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] op,
    output cls_t       cls
);
    assign cls.load      = op == OP_LW;
    assign cls.store     = op == OP_SW;
    assign cls.rtype     = op == OP_R;
    assign cls.addi      = op == OP_ADDI;
    assign cls.branch_eq = op == OP_BEQ;
`ifdef CTRL_BNE_EN
    assign cls.branch_ne = op == OP_BNE;
`else
    assign cls.branch_ne = 1'b0;
`endif
    assign cls.jump      = op == OP_J;
    assign cls.halt      = op == OP_HALT;
    assign cls.illegal   = !(cls.load | cls.store | cls.rtype | cls.addi | cls.branch_eq |
                             cls.branch_ne | cls.jump | cls.halt);
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with MEM timeout and retire counter
//   clk, rst  clock, synchronous active-high reset
//   bus       mc_control_unit_if.master (opcode/mem_ack in, strobes and status out)
//   MEM_TIMEOUT  MEM cycles without mem_ack before FAULT (1..255); CNT_W retire counter width
//   CTRL_BNE_EN  when defined, opcode 0101 decodes as BNE; otherwise it is illegal
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    mc_control_unit_if.master bus
);
    state_t           state, nxt;
    logic [3:0]       opcode_q;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q;
    cls_t             c;
    logic             ir_load, pc_en, reg_dst, alu_src, mem_to_reg, reg_write;
    logic             mem_read, mem_write, beq, bne, jump;
    logic [1:0]       alu_op;
    logic             timeout;

    ctrl_decode u_dec (.op(opcode_q), .cls(c));

    // wait_cnt holds the number of MEM cycles already completed, so the last allowed cycle is MEM_TIMEOUT-1
    assign timeout = wait_cnt == 8'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            opcode_q  <= 4'b0;
            wait_cnt  <= 8'b0;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= nxt;
            opcode_q  <= state == S_FETCH ? bus.opcode : opcode_q;
            wait_cnt  <= state == S_MEM ? wait_cnt + 8'd1 : 8'd0;
            cnt       <= pc_en ? cnt + 1'b1 : cnt;
            illegal_q <= illegal_q | (state == S_DECODE && c.illegal);
        end
    end

    always_comb begin
        nxt        = state;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        jump       = 1'b0;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_load = 1'b1;
                nxt     = S_DECODE;
            end
            S_DECODE: begin
                pc_en = c.illegal;
                nxt   = c.halt ? S_HALT : c.illegal ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                alu_src = c.load | c.store | c.addi;
                reg_dst = c.rtype;
                alu_op  = c.rtype ? ALUOP_FUNCT : (c.branch_eq | c.branch_ne) ? ALUOP_SUB : ALUOP_ADD;
                beq     = c.branch_eq;
                bne     = c.branch_ne;
                jump    = c.jump;
                pc_en   = c.branch_eq | c.branch_ne | c.jump;
                nxt     = pc_en ? S_FETCH : (c.load | c.store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = c.load;
                mem_write = c.store;
                // a store completes in MEM itself, so its PC strobe follows the acknowledge
                pc_en     = c.store & bus.mem_ack;
                nxt       = bus.mem_ack ? (c.load ? S_WB : S_FETCH) : timeout ? S_FAULT : S_MEM;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_en      = 1'b1;
                reg_dst    = c.rtype;
                mem_to_reg = c.load;
                alu_src    = c.load | c.addi;
                alu_op     = c.rtype ? ALUOP_FUNCT : ALUOP_ADD;
                nxt        = S_FETCH;
            end
            default: nxt = state;
        endcase
    end

    // every output is forced low while reset is asserted, including the first reset cycle
    assign bus.ir_load    = ir_load & ~rst;
    assign bus.pc_en      = pc_en & ~rst;
    assign bus.reg_dst    = reg_dst & ~rst;
    assign bus.alu_src    = alu_src & ~rst;
    assign bus.mem_to_reg = mem_to_reg & ~rst;
    assign bus.reg_write  = reg_write & ~rst;
    assign bus.mem_read   = mem_read & ~rst;
    assign bus.mem_write  = mem_write & ~rst;
    assign bus.beq        = beq & ~rst;
    assign bus.bne        = bne & ~rst;
    assign bus.jump       = jump & ~rst;
    assign bus.alu_op     = rst ? 2'b00 : alu_op;
    assign bus.retire_cnt = rst ? '0 : cnt;
    assign bus.illegal    = illegal_q & ~rst;
    assign bus.fault      = state == S_FAULT && !rst;
    assign bus.halted     = state == S_HALT && !rst;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed scoreboard bench for mc_control_unit
module tb_mc_control_unit;
    localparam logic [15:0] IR  = 16'h8000, PC  = 16'h4000, RD  = 16'h2000, AS  = 16'h1000;
    localparam logic [15:0] M2R = 16'h0800, RW  = 16'h0400, MRD = 16'h0200, MWR = 16'h0100;
    localparam logic [15:0] BQ  = 16'h0080, BN  = 16'h0040, JP  = 16'h0020, FN  = 16'h0010;
    localparam logic [15:0] SUB = 16'h0008, ILL = 16'h0004, FLT = 16'h0002, HLT = 16'h0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_control_unit_if #(.CNT_W(16)) bus ();
    mc_control_unit #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] sb[$];
    logic [15:0] rc  = 16'd0;
    logic [15:0] ill = 16'd0;
    int nvec = 0;
    int nerr = 0;

    task automatic cyc(input string tag, input logic [15:0] e);
        logic [31:0] x;
        logic [15:0] obs;
        sb.push_back(rst ? 32'd0 : {e | ill, rc});
        @(negedge clk);
        x = sb.pop_front();
        obs = {bus.ir_load, bus.pc_en, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write,
               bus.mem_read, bus.mem_write, bus.beq, bus.bne, bus.jump, bus.alu_op,
               bus.illegal, bus.fault, bus.halted};
        nvec++;
        assert (obs === x[31:16]) else begin
            nerr++;
            $error("FAIL %s outs got %h want %h", tag, obs, x[31:16]);
        end
        nvec++;
        assert (bus.retire_cnt === x[15:0]) else begin
            nerr++;
            $error("FAIL %s retire_cnt got %0d want %0d", tag, bus.retire_cnt, x[15:0]);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            rc  = 16'd0;
            ill = 16'd0;
        end else if ((e & PC) != 16'd0) rc = rc + 16'd1;
    endtask

    task automatic fd(input logic [3:0] op);
        bus.opcode = op;
        cyc("fetch", IR);
        bus.opcode = 4'hA;
        cyc("decode", 16'd0);
    endtask

    initial begin
        bus.opcode  = 4'd0;
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 16'd0);
        rst = 1'b0;
        // R-type
        fd(4'b0010);
        cyc("r_exec", RD | FN);
        cyc("r_wb", RW | PC | RD | FN);
        // BEQ then J
        fd(4'b0100);
        cyc("beq_exec", BQ | SUB | PC);
        fd(4'b0110);
        cyc("j_exec", JP | PC);
        // ADDI with mem_ack held high outside MEM: must be ignored
        bus.mem_ack = 1'b1;
        fd(4'b0011);
        cyc("addi_exec", AS);
        cyc("addi_wb", RW | PC | AS);
        bus.mem_ack = 1'b0;
        // LW with ack after 3 wait cycles
        fd(4'b0000);
        cyc("lw_exec", AS);
        repeat (3) cyc("lw_wait", AS | MRD);
        bus.mem_ack = 1'b1;
        cyc("lw_ack", AS | MRD);
        bus.mem_ack = 1'b0;
        cyc("lw_wb", RW | PC | AS | M2R);
        // SW with zero-wait ack
        fd(4'b0001);
        cyc("sw_exec", AS);
        bus.mem_ack = 1'b1;
        cyc("sw_ack", AS | MWR | PC);
        bus.mem_ack = 1'b0;
        // opcode 0101
`ifdef CTRL_BNE_EN
        fd(4'b0101);
        cyc("bne_exec", BN | SUB | PC);
`else
        bus.opcode = 4'b0101;
        cyc("ill5_fetch", IR);
        cyc("ill5_decode", PC);
        ill = ILL;
`endif
        // undefined opcode 0111
        bus.opcode = 4'b0111;
        cyc("ill7_fetch", IR);
        cyc("ill7_decode", PC);
        ill = ILL;
        // LW with ack on the last allowed MEM cycle
        fd(4'b0000);
        cyc("lw15_exec", AS);
        repeat (14) cyc("lw15_wait", AS | MRD);
        bus.mem_ack = 1'b1;
        cyc("lw15_ack", AS | MRD);
        bus.mem_ack = 1'b0;
        cyc("lw15_wb", RW | PC | AS | M2R);
        // SW timeout into FAULT
        fd(4'b0001);
        cyc("sw_exec2", AS);
        repeat (15) cyc("sw_wait", AS | MWR);
        cyc("fault", FLT);
        bus.mem_ack = 1'b1;
        repeat (3) cyc("fault_hold", FLT);
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        cyc("fault_rst", 16'd0);
        rst = 1'b0;
        // HALT
        fd(4'b1111);
        repeat (100) cyc("halted", HLT);
        rst = 1'b1;
        cyc("halt_rst", 16'd0);
        rst = 1'b0;
        // reset in the middle of MEM
        fd(4'b0000);
        cyc("lwr_exec", AS);
        repeat (2) cyc("lwr_wait", AS | MRD);
        rst = 1'b1;
        cyc("mem_rst", 16'd0);
        rst = 1'b0;
        bus.opcode = 4'b0010;
        cyc("after_rst", IR);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
